// File: rtl/text_char_buffer_if.sv
// Host-side bus for the text character buffer: logical-address read/write
// requests from the host, read data and its valid pulse back from the buffer.
interface text_char_buffer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CHAR_W = 8
);
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] wdata;
    logic [CHAR_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output ren, wen, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  ren, wen, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/text_char_buffer.sv
// Text-mode character memory of ROWS x COLS cells. The host sees logical
// addresses (row*COLS + col); a rotating top-row pointer maps logical rows to
// physical rows so a scroll only has to blank one physical row. A separate
// display port reads any logical cell with one cycle of latency, even while a
// clear or scroll sweep is running.
module text_char_buffer #(
    parameter int unsigned       COLS      = 64,
    parameter int unsigned       ROWS      = 20,
    parameter int unsigned       CHAR_W    = 8,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(8'h20)
) (
    input  logic                     clk,
    input  logic                     reset,
    text_char_buffer_if.slave        host,
    input  logic                     scroll,
    input  logic                     clear,
    output logic                     busy,
    output logic                     error,
    input  logic [$clog2(ROWS)-1:0]  disp_row,
    input  logic [$clog2(COLS)-1:0]  disp_col,
    output logic [CHAR_W-1:0]        disp_char
);

    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned CW     = $clog2(COLS);
    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned CNTW   = $clog2(CELLS);
    localparam logic [RW:0] ROWS_X = (RW+1)'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SCROLL
    } state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [RW-1:0]     r_top;
    logic [RW-1:0]     r_scroll_row;
    logic [CHAR_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_error;
    logic [CHAR_W-1:0] r_disp_char;
    logic [CHAR_W-1:0] r_mem [ROWS][COLS];

    logic              w_idle;
    logic              w_req;
    logic              w_in_range;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_err_next;
    logic [RW-1:0]     w_h_lrow;
    logic [CW-1:0]     w_h_col;
    logic [RW-1:0]     w_h_prow;
    logic [RW-1:0]     w_sw_row;
    logic [CW-1:0]     w_sw_col;
    logic              w_d_ok;
    logic [RW-1:0]     w_d_prow;
    logic [RW-1:0]     w_top_next;

    // Logical-to-physical row: (a + b) mod ROWS for a, b both below ROWS.
    function automatic logic [RW-1:0] f_wrap(input logic [RW-1:0] a,
                                             input logic [RW-1:0] b);
        logic [RW:0] v_sum;
        v_sum = {1'b0, a} + {1'b0, b};
        if (v_sum >= ROWS_X) begin
            v_sum = v_sum - ROWS_X;
        end
        return v_sum[RW-1:0];
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign w_req      = host.ren | host.wen;
    assign w_in_range = (32'(host.addr) < CELLS);
    assign w_h_lrow   = RW'(32'(host.addr) / COLS);
    assign w_h_col    = CW'(32'(host.addr) % COLS);
    assign w_h_prow   = f_wrap(w_h_lrow, r_top);
    assign w_rd_ok    = w_idle & host.ren & ~host.wen & w_in_range;
    assign w_wr_ok    = w_idle & host.wen & ~host.ren & w_in_range;
    assign w_err_next = (host.ren & host.wen)
                      | (w_req & ~w_in_range)
                      | (w_req & ~w_idle)
                      | (scroll & ~w_idle);
    assign w_top_next = (r_top == RW'(ROWS - 1)) ? '0 : r_top + RW'(1);

    assign w_d_ok   = (32'(disp_row) < ROWS) && (32'(disp_col) < COLS);
    assign w_d_prow = f_wrap(disp_row, r_top);

    // Sweep target: CLEAR walks every physical cell, SCROLL walks the saved row.
    always_comb begin
        w_sw_row = RW'(32'(r_cnt) / COLS);
        w_sw_col = CW'(32'(r_cnt) % COLS);
        if (r_state == S_SCROLL) begin
            w_sw_row = r_scroll_row;
            w_sw_col = CW'(r_cnt);
        end
    end

    // Character store: host writes when idle, otherwise the sweep blanks one cell per cycle.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_h_prow][w_h_col] <= host.wdata;
        end else if (!w_idle) begin
            r_mem[w_sw_row][w_sw_col] <= FILL_CHAR;
        end
    end

    // Control FSM with registered host, error and display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_top        <= '0;
            r_scroll_row <= '0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_error      <= 1'b0;
            r_disp_char  <= '0;
        end else begin
            r_error     <= w_err_next;
            r_rvalid    <= w_rd_ok;
            if (w_rd_ok) begin
                r_rdata <= r_mem[w_h_prow][w_h_col];
            end
            r_disp_char <= w_d_ok ? r_mem[w_d_prow][disp_col] : FILL_CHAR;

            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_top   <= '0;
                    end else if (scroll) begin
                        // Old top row becomes the new bottom row and is blanked.
                        r_state      <= S_SCROLL;
                        r_cnt        <= '0;
                        r_scroll_row <= r_top;
                        r_top        <= w_top_next;
                    end
                end
                S_CLEAR: begin
                    if (clear) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNTW'(CELLS - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_SCROLL: begin
                    if (clear) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_top   <= '0;
                    end else if (r_cnt == CNTW'(COLS - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy        = ~w_idle;
    assign error       = r_error;
    assign disp_char   = r_disp_char;
    assign host.rdata  = r_rdata;
    assign host.rvalid = r_rvalid;

endmodule

// File: tb/tb_text_char_buffer.sv
// Directed bench for text_char_buffer. A logical-cell reference array is
// updated by plain row shifts on scroll, independent of any top pointer;
// read expectations are queued when a read is issued and popped on rvalid.
module tb_text_char_buffer;

    localparam int         COLS  = 64;
    localparam int         ROWS  = 20;
    localparam int         CELLS = ROWS * COLS;
    localparam logic [7:0] FILL  = 8'h20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scroll = 1'b0;
    logic       clear = 1'b0;
    logic       busy;
    logic       error;
    logic [4:0] disp_row = '0;
    logic [5:0] disp_col = '0;
    logic [7:0] disp_char;

    int checks = 0;
    int errors = 0;

    logic [7:0] lmem [CELLS];
    logic [7:0] exp_q [$];

    text_char_buffer_if #(.ADDR_W(16), .CHAR_W(8)) hif ();

    text_char_buffer #(
        .COLS(COLS),
        .ROWS(ROWS),
        .CHAR_W(8),
        .ADDR_W(16),
        .FILL_CHAR(8'h20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host(hif),
        .scroll(scroll),
        .clear(clear),
        .busy(busy),
        .error(error),
        .disp_row(disp_row),
        .disp_col(disp_col),
        .disp_char(disp_char)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) lmem[i] = FILL;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < CELLS - COLS; i++) lmem[i] = lmem[i + COLS];
        for (int i = CELLS - COLS; i < CELLS; i++) lmem[i] = FILL;
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        hif.wen   = 1'b1;
        hif.addr  = 16'(a);
        hif.wdata = d;
        step();
        hif.wen = 1'b0;
        chk("wr_err", error, 0);
        lmem[a] = d;
    endtask

    task automatic do_read(input int a);
        exp_q.push_back(lmem[a]);
        hif.ren  = 1'b1;
        hif.addr = 16'(a);
        step();
        hif.ren = 1'b0;
        chk("rd_err", error, 0);
        chk("rd_rvalid", hif.rvalid, 1);
        if (hif.rvalid === 1'b1 && exp_q.size() > 0) begin
            chk("rd_data", hif.rdata, exp_q.pop_front());
        end
    endtask

    task automatic bad_req(input string tag, input logic r, input logic w, input int a);
        hif.ren   = r;
        hif.wen   = w;
        hif.addr  = 16'(a);
        hif.wdata = 8'h99;
        step();
        hif.ren = 1'b0;
        hif.wen = 1'b0;
        chk(tag, error, 1);
        chk({tag, "_rvalid"}, hif.rvalid, 0);
    endtask

    task automatic wait_sweep(input string tag, input int exp);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            step();
        end
        chk(tag, n, exp);
    endtask

    task automatic do_scroll();
        scroll = 1'b1;
        step();
        scroll = 1'b0;
        model_scroll();
        wait_sweep("scroll_len", 64);
    endtask

    task automatic chk_disp(input int r, input int c);
        disp_row = 5'(r);
        disp_col = 6'(c);
        step();
        chk("disp", disp_char, (r < ROWS) ? lmem[r * COLS + c] : FILL);
    endtask

    initial begin
        hif.ren   = 1'b0;
        hif.wen   = 1'b0;
        hif.addr  = '0;
        hif.wdata = '0;
        model_clear();

        // Reset and power-up clear
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_rvalid", hif.rvalid, 0);
        chk("rst_error", error, 0);
        chk("rst_rdata", hif.rdata, 0);
        chk("rst_disp", disp_char, 0);
        reset = 1'b1;
        wait_sweep("init_clear_len", 1280);
        do_read(0);
        do_read(1279);
        step();
        chk("rvalid_pulse", hif.rvalid, 0);

        // Write then read back through host and display ports
        do_write(65, 8'h41);
        do_read(65);
        chk_disp(1, 1);
        chk_disp(21, 1);
        chk_disp(0, 63);

        // Protocol errors
        bad_req("err_ren_wen", 1'b1, 1'b1, 5);
        step();
        chk("err_clears", error, 0);
        do_read(5);
        bad_req("err_wr_oor", 1'b0, 1'b1, 1280);
        bad_req("err_rd_oor", 1'b1, 1'b0, 16'hFFFF);
        do_read(1279);

        // Scroll with requests while busy
        do_write(64, 8'h42);
        scroll = 1'b1;
        step();
        scroll = 1'b0;
        model_scroll();
        chk("scroll_busy_on", busy, 1);
        hif.wen   = 1'b1;
        hif.addr  = 16'd10;
        hif.wdata = 8'h77;
        step();
        hif.wen = 1'b0;
        chk("err_wr_busy", error, 1);
        scroll = 1'b1;
        step();
        scroll = 1'b0;
        chk("err_scroll_busy", error, 1);
        wait_sweep("scroll_len_rest", 62);
        do_read(0);
        do_read(1216);
        do_read(1);
        do_read(10);
        chk_disp(0, 0);

        // Tag every row, scroll through a full wrap of the top pointer
        for (int r = 0; r < ROWS; r++) do_write(r * COLS + 2, 8'h60 + 8'(r));
        do_scroll();
        do_read(2);
        do_read(1218);
        for (int k = 0; k < 9; k++) do_scroll();
        do_read(2);
        do_read(9 * COLS + 2);
        do_read(10 * COLS + 2);
        chk_disp(9, 2);
        for (int k = 0; k < 10; k++) do_scroll();
        do_read(2);
        do_write(0, 8'h55);
        do_read(0);
        chk_disp(0, 0);
        do_write(1279, 8'h7E);
        do_read(1279);
        chk_disp(19, 63);

        // Clear and scroll together: clear only
        clear  = 1'b1;
        scroll = 1'b1;
        step();
        clear  = 1'b0;
        scroll = 1'b0;
        model_clear();
        wait_sweep("clear_scroll_len", 1280);
        do_read(0);
        do_read(1279);

        // Clear aborts a scroll in progress
        do_write(70, 8'h33);
        scroll = 1'b1;
        step();
        scroll = 1'b0;
        repeat (5) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        wait_sweep("clear_abort_len", 1280);
        do_read(6);
        do_read(70);
        do_write(64, 8'h11);
        do_scroll();
        do_read(0);

        // Reset in the middle of a clear sweep
        do_write(3, 8'h5A);
        do_read(3);
        disp_row = 5'd21;
        disp_col = 6'd0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        repeat (10) step();
        hif.ren  = 1'b1;
        hif.addr = 16'd0;
        step();
        hif.ren = 1'b0;
        chk("err_rd_busy", error, 1);
        chk("disp_oor_fill", disp_char, FILL);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_rdata", hif.rdata, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_rvalid", hif.rvalid, 0);
        chk("mid_rst_disp", disp_char, 0);
        disp_row = 5'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_sweep("reset_restart_len", 1280);
        do_read(3);
        do_read(1279);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
